// File: rtl/io_input_line_capture.sv
// ---------------------------------------------------------------------------
// io_input_line_capture
//   Arms on onYourMark, starts on GOGOGO_EXCLAMATION, then measures the lead
//   time from trigger to the line leaving its rest level and the width of the
//   resulting pulse, in clock cycles. Optional timeout, hardStop abort.
//
//   Optional feature: define IO_INPUT_GLITCH_FILTER_EN to insert a glitch
//   filter (FILTER_LEN consecutive samples) after the synchronizer.
//
// Ports
//   clk                 system clock
//   rst                 synchronous active-low reset
//   lineIn              asynchronous external IO line
//   restLevel           idle level of lineIn (active = ~restLevel)
//   onYourMark          arm request
//   GOGOGO_EXCLAMATION  trigger, accepted only while armed
//   timeout[31:0]       max cycles trigger->completion, 0 = none
//   hardStop            abort to IDLE, highest priority after rst
//   lineState           synchronized (and filtered) line level
//   leadTime[31:0]      cycles from trigger to first active sample
//   pulseWidth[31:0]    cycles lineState held active
//   captureValid        full pulse captured
//   timedOut            capture ended by timeout
//   busy                capture in progress
// ---------------------------------------------------------------------------
module io_input_line_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lineIn,
    input  logic        restLevel,
    input  logic        onYourMark,
    input  logic        GOGOGO_EXCLAMATION,
    input  logic [31:0] timeout,
    input  logic        hardStop,
    output logic        lineState,
    output logic [31:0] leadTime,
    output logic [31:0] pulseWidth,
    output logic        captureValid,
    output logic        timedOut,
    output logic        busy
);

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_EDGE,
        S_IN_PULSE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]   r_lead_cnt;
    logic [CW-1:0]   r_width_cnt;
    logic [CW-1:0]   r_elapsed;
    logic [CW-1:0]   r_timeout;
    logic            r_rest;

    logic            w_active;
    logic            w_tmo_hit;
    logic [CW-1:0]   w_lead_inc;
    logic [CW-1:0]   w_width_inc;
    logic [CW-1:0]   w_elapsed_inc;

    // Input synchronizer; new samples enter at bit 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{restLevel}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], lineIn};
        end
    end

`ifdef IO_INPUT_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] r_fcnt;
    logic           r_filt;

    // Accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_filt <= restLevel;
            r_fcnt <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + FCW'(1);
        end
    end

    assign lineState = r_filt;
`else
    // FILTER_LEN has no effect in the unfiltered build
    logic w_unused_filter_len;
    assign w_unused_filter_len = ^FILTER_LEN;

    assign lineState = r_sync[SYNC_STAGES-1];
`endif

    // Activity is judged against the rest level captured at trigger time
    assign w_active      = (lineState != r_rest);
    assign w_tmo_hit     = (r_timeout != '0) && (r_elapsed == (r_timeout - CW'(1)));
    assign w_lead_inc    = (r_lead_cnt  == CNT_MAX) ? CNT_MAX : r_lead_cnt  + CW'(1);
    assign w_width_inc   = (r_width_cnt == CNT_MAX) ? CNT_MAX : r_width_cnt + CW'(1);
    assign w_elapsed_inc = (r_elapsed   == CNT_MAX) ? CNT_MAX : r_elapsed   + CW'(1);

    // Capture FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_lead_cnt   <= '0;
            r_width_cnt  <= '0;
            r_elapsed    <= '0;
            r_timeout    <= '0;
            r_rest       <= restLevel;
            leadTime     <= '0;
            pulseWidth   <= '0;
            captureValid <= 1'b0;
            timedOut     <= 1'b0;
            busy         <= 1'b0;
        end else if (hardStop) begin
            // Results and flags survive an abort; only the work counters clear
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            r_lead_cnt  <= '0;
            r_width_cnt <= '0;
            r_elapsed   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (onYourMark) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!onYourMark) begin
                        r_state <= S_IDLE;
                    end else if (GOGOGO_EXCLAMATION) begin
                        r_state      <= S_WAIT_EDGE;
                        busy         <= 1'b1;
                        r_lead_cnt   <= '0;
                        r_width_cnt  <= '0;
                        r_elapsed    <= '0;
                        r_timeout    <= timeout;
                        r_rest       <= restLevel;
                        leadTime     <= '0;
                        pulseWidth   <= '0;
                        captureValid <= 1'b0;
                        timedOut     <= 1'b0;
                    end
                end
                S_WAIT_EDGE: begin
                    r_elapsed <= w_elapsed_inc;
                    if (w_tmo_hit) begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        timedOut <= 1'b1;
                        leadTime <= r_lead_cnt;
                    end else if (w_active) begin
                        r_state     <= S_IN_PULSE;
                        leadTime    <= r_lead_cnt;
                        r_width_cnt <= CW'(1);
                    end else begin
                        r_lead_cnt <= w_lead_inc;
                    end
                end
                S_IN_PULSE: begin
                    r_elapsed <= w_elapsed_inc;
                    // Pulse end takes precedence over a coincident timeout
                    if (!w_active) begin
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        pulseWidth   <= r_width_cnt;
                        captureValid <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_state    <= S_DONE;
                        busy       <= 1'b0;
                        timedOut   <= 1'b1;
                        pulseWidth <= r_width_cnt;
                    end else begin
                        r_width_cnt <= w_width_inc;
                    end
                end
                S_DONE: begin
                    if (!onYourMark) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_line_capture.sv
module tb_io_input_line_capture;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 4;
`ifdef IO_INPUT_GLITCH_FILTER_EN
    localparam int unsigned FLT = FILTER_LEN;
`else
    localparam int unsigned FLT = 0;
`endif
    // Cycles from a lineIn change being sampled to lineState reflecting it, minus one edge
    localparam int unsigned LAT  = SYNC_STAGES + FLT;
    localparam int unsigned WMIN = (FLT > 0) ? FLT : 1;

    logic        clk;
    logic        rst;
    logic        lineIn;
    logic        restLevel;
    logic        onYourMark;
    logic        GOGOGO_EXCLAMATION;
    logic [31:0] timeout;
    logic        hardStop;
    logic        lineState;
    logic [31:0] leadTime;
    logic [31:0] pulseWidth;
    logic        captureValid;
    logic        timedOut;
    logic        busy;

    int n_pass;
    int n_total;

    io_input_line_capture #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lineIn             (lineIn),
        .restLevel          (restLevel),
        .onYourMark         (onYourMark),
        .GOGOGO_EXCLAMATION (GOGOGO_EXCLAMATION),
        .timeout            (timeout),
        .hardStop           (hardStop),
        .lineState          (lineState),
        .leadTime           (leadTime),
        .pulseWidth         (pulseWidth),
        .captureValid       (captureValid),
        .timedOut           (timedOut),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rest;
        logic        pre;
        int unsigned d;
        int unsigned w;
        int unsigned gd;
        int unsigned gw;
        int unsigned to;
        int unsigned e_lead;
        int unsigned e_width;
        logic        e_valid;
        logic        e_tmo;
    } vec_t;

    typedef struct {
        int unsigned lead;
        int unsigned width;
        logic        valid;
        logic        tmo;
    } exp_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic line_active(input logic pre, input int unsigned k,
                                         input int unsigned d, input int unsigned w,
                                         input int unsigned gd, input int unsigned gw);
        logic a;
        if (pre) a = (k < d);
        else     a = (k >= d) && (k < d + w);
        if (gw != 0 && k >= gd && k < gd + gw) a = 1'b1;
        return a;
    endfunction

    // Reference: the FSM first sees the line active d+LAT+1 edges after the
    // trigger edge and sees it inactive again w edges later.
    function automatic exp_t model(input int unsigned d, input int unsigned w, input int unsigned to);
        exp_t        e;
        int unsigned first_seen;
        int unsigned done_edge;
        first_seen = d + LAT + 1;
        done_edge  = first_seen + w;
        e.lead  = 0;
        e.width = 0;
        e.valid = 1'b0;
        e.tmo   = 1'b0;
        if (to != 0 && to < done_edge) begin
            e.tmo = 1'b1;
            if (to <= first_seen) begin
                e.lead = to - 1;
            end else begin
                e.lead  = d + LAT;
                e.width = to - first_seen;
            end
        end else begin
            e.lead  = d + LAT;
            e.width = w;
            e.valid = 1'b1;
        end
        return e;
    endfunction

    // Idle with the line at rest (or pre-active), arm, trigger, then play the line
    // pattern for ncyc cycles, one lineIn value per clock after the trigger edge.
    task automatic run_capture(input logic rest, input logic pre, input int unsigned d,
                               input int unsigned w, input int unsigned gd, input int unsigned gw,
                               input int unsigned to, input int unsigned ncyc);
        @(negedge clk);
        hardStop           = 1'b0;
        onYourMark         = 1'b0;
        GOGOGO_EXCLAMATION = 1'b0;
        timeout            = '0;
        restLevel          = rest;
        lineIn             = rest ^ pre;
        repeat (12) @(negedge clk);
        onYourMark = 1'b1;
        @(negedge clk);
        GOGOGO_EXCLAMATION = 1'b1;
        timeout            = to;
        @(negedge clk);
        // Disturb sampled-at-trigger inputs to confirm they were captured
        GOGOGO_EXCLAMATION = 1'b0;
        timeout            = $urandom;
        restLevel          = ~rest;
        check("busy_after_go", 32'(busy), 32'd1);
        for (int unsigned k = 0; k < ncyc; k++) begin
            lineIn = rest ^ line_active(pre, k, d, w, gd, gw);
            @(negedge clk);
        end
        lineIn    = rest;
        restLevel = rest;
    endtask

    function automatic int unsigned run_len(input vec_t v);
        int unsigned c;
        c = v.d + LAT + v.w + 1;
        if (v.to > c) c = v.to;
        return c + 4;
    endfunction

    task automatic check_results(input string tag, input int unsigned e_lead, input int unsigned e_width,
                                 input logic e_valid, input logic e_tmo);
        check({tag, ".leadTime"},     leadTime,           32'(e_lead));
        check({tag, ".pulseWidth"},   pulseWidth,         32'(e_width));
        check({tag, ".captureValid"}, 32'(captureValid),  32'(e_valid));
        check({tag, ".timedOut"},     32'(timedOut),      32'(e_tmo));
        check({tag, ".busy_end"},     32'(busy),          32'd0);
    endtask

    initial begin
        vec_t        v;
        exp_t        e;
        int unsigned c;

        n_pass             = 0;
        n_total            = 0;
        rst                = 1'b0;
        lineIn             = 1'b1;
        restLevel          = 1'b1;
        onYourMark         = 1'b0;
        GOGOGO_EXCLAMATION = 1'b0;
        timeout            = '0;
        hardStop           = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.lineState",    32'(lineState),    32'd1);
        check("reset.leadTime",     leadTime,          32'd0);
        check("reset.pulseWidth",   pulseWidth,        32'd0);
        check("reset.captureValid", 32'(captureValid), 32'd0);
        check("reset.timedOut",     32'(timedOut),     32'd0);
        check("reset.busy",         32'(busy),         32'd0);
        rst = 1'b1;

        // rest pre d w gd gw to | lead width valid tmo
        vecs.push_back('{1'b0, 1'b0, 10, 5,    0, 0, 0,        10 + LAT, 5,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 0,  0,    0, 0, 20,       19,       0,       1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3,  6,    0, 0, 0,        3 + LAT,  6,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2,  4,    0, 0, 2+LAT+5,  2 + LAT,  4,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 2,  4,    0, 0, 2+LAT+4,  2 + LAT,  3,       1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 5,  3,    0, 0, 1,        0,        0,       1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 7,  0,    0, 0, 0,        0,        7 + LAT, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 0,  WMIN, 0, 0, 0,        LAT,      WMIN,    1'b1, 1'b0});
`ifdef IO_INPUT_GLITCH_FILTER_EN
        // 3-cycle glitch must not end the wait; lead grows by the filter latency
        vecs.push_back('{1'b0, 1'b0, 10, 6,    2, 3, 0,        10 + SYNC_STAGES + 4, 6, 1'b1, 1'b0});
`endif

        foreach (vecs[i]) begin
            v = vecs[i];
            run_capture(v.rest, v.pre, v.d, v.w, v.gd, v.gw, v.to, run_len(v));
            check_results($sformatf("vec%0d", i), v.e_lead, v.e_width, v.e_valid, v.e_tmo);
        end

        // Randomized captures against the arithmetic model
        for (int t = 0; t < 30; t++) begin
            v.rest = 1'($urandom_range(0, 1));
            v.pre  = 1'b0;
            v.d    = $urandom_range(0, 15);
            v.w    = $urandom_range(WMIN, 12);
            v.gd   = 0;
            v.gw   = 0;
            c      = v.d + LAT + v.w + 1;
            v.to   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, c + 3);
            if (v.to == v.d + LAT + 1) v.to = 0;
            e = model(v.d, v.w, v.to);
            run_capture(v.rest, v.pre, v.d, v.w, v.gd, v.gw, v.to, run_len(v));
            check_results($sformatf("rnd%0d", t), e.lead, e.width, e.valid, e.tmo);
        end

        // hardStop after a timeout keeps flags and results
        run_capture(1'b0, 1'b0, 0, 0, 0, 0, 8, 12);
        hardStop = 1'b1;
        @(negedge clk);
        hardStop = 1'b0;
        check("stop_keep.timedOut", 32'(timedOut), 32'd1);
        check("stop_keep.leadTime", leadTime,      32'd7);
        check("stop_keep.busy",     32'(busy),     32'd0);

        // hardStop in the middle of a pulse
        run_capture(1'b0, 1'b0, 2, 30, 0, 0, 0, 2 + LAT + 5);
        check("abort.busy_before", 32'(busy), 32'd1);
        hardStop = 1'b1;
        @(negedge clk);
        hardStop   = 1'b0;
        onYourMark = 1'b0;
        check("abort.busy",         32'(busy),         32'd0);
        check("abort.captureValid", 32'(captureValid), 32'd0);
        check("abort.timedOut",     32'(timedOut),     32'd0);
        check("abort.leadTime",     leadTime,          32'(2 + LAT));
        check("abort.pulseWidth",   pulseWidth,        32'd0);
        repeat (3) @(negedge clk);
        check("abort.stays_idle",   32'(busy),         32'd0);

        // Reset in the middle of a capture
        run_capture(1'b0, 1'b0, 3, 30, 0, 0, 0, 3 + LAT + 5);
        rst = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        onYourMark = 1'b0;
        check("rstmid.leadTime",     leadTime,          32'd0);
        check("rstmid.pulseWidth",   pulseWidth,        32'd0);
        check("rstmid.captureValid", 32'(captureValid), 32'd0);
        check("rstmid.timedOut",     32'(timedOut),     32'd0);
        check("rstmid.busy",         32'(busy),         32'd0);
        check("rstmid.lineState",    32'(lineState),    32'd0);

        // Handshake: trigger without arm, then arm+trigger together, then trigger
        @(negedge clk);
        GOGOGO_EXCLAMATION = 1'b1;
        @(negedge clk);
        check("hs.go_unarmed_1", 32'(busy), 32'd0);
        @(negedge clk);
        check("hs.go_unarmed_2", 32'(busy), 32'd0);
        onYourMark = 1'b1;
        @(negedge clk);
        check("hs.arm_only", 32'(busy), 32'd0);
        @(negedge clk);
        GOGOGO_EXCLAMATION = 1'b0;
        check("hs.go_armed", 32'(busy), 32'd1);
        onYourMark = 1'b0;
        repeat (3) @(negedge clk);
        check("hs.arm_drop_ignored", 32'(busy), 32'd1);
        hardStop = 1'b1;
        @(negedge clk);
        hardStop = 1'b0;
        check("hs.stopped", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
